// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding, default frame marker and instruction width.
package imem_loader_pkg;

  localparam int         INSN_W       = 32;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  // Terminal states park the stream until the host rearms.
  function automatic logic accepts(state_e s);
    return (s != DONE) && (s != ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader.
// master = host/memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSN_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// 8->32 big-endian packer; word_o/word_valid_o are registered, so the
// word appears the cycle after its fourth byte is accepted.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  output logic              word_done_o,
  output logic              word_valid_o,
  output logic [INSN_W-1:0] word_o
);

  logic [1:0]        cnt_q;
  logic [INSN_W-9:0] shift_q;
  logic [INSN_W-1:0] word_q;
  logic              vld_q;

  assign word_done_o  = accept_i && (cnt_q == 2'd3);
  assign word_valid_o = vld_q;
  assign word_o       = word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (accept_i) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[INSN_W-17:0], byte_i};
        if (cnt_q == 2'd3) begin
          word_q <= {shift_q, byte_i};
          vld_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the fetch-side instruction memory; keeps
// the core held until a frame with a good checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_loader_if.slave    bus,
  input  logic            rearm_i,
  output logic            core_hold_o,
  output logic            load_done_o,
  output logic            load_err_o,
  output logic [ADDR_W:0] words_loaded_o
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic              in_ready_q, hold_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_q;
  logic [7:0]        chk_q;
  logic [15:0]       len_q;

  logic              accept, sync_hit, word_done, last_word, pk_vld;
  logic [15:0]       len_d;
  logic [INSN_W-1:0] pk_word;

  assign accept    = bus.in_valid && in_ready_q;
  assign sync_hit  = accept && (state_q == IDLE) && (bus.in_data == SYNC_BYTE);
  assign len_d     = {len_q[15:8], bus.in_data};
  assign last_word = (16'(words_q) + 16'd1) == len_q;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (sync_hit),
    .accept_i     (accept && (state_q == DATA)),
    .byte_i       (bus.in_data),
    .word_done_o  (word_done),
    .word_valid_o (pk_vld),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (sync_hit) state_d = LEN_HI;
      LEN_HI: if (accept) state_d = LEN_LO;
      LEN_LO: if (accept) begin
        if (len_d == '0)             state_d = CHECK;
        else if ({1'b0, len_d} > CAP) state_d = ERROR;
        else                          state_d = DATA;
      end
      DATA:   if (word_done && last_word) state_d = CHECK;
      CHECK:  if (accept) state_d = (bus.in_data == chk_q) ? DONE : ERROR;
      DONE, ERROR: if (rearm_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      words_q    <= '0;
      chk_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= accepts(state_d);
      hold_q     <= (state_d != DONE);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERROR);

      if (sync_hit) begin
        chk_q   <= '0;
        words_q <= '0;
      end
      if (accept && (state_q inside {LEN_HI, LEN_LO, DATA}))
        chk_q <= chk_q ^ bus.in_data;
      if (accept && (state_q == LEN_HI)) len_q[15:8] <= bus.in_data;
      if (accept && (state_q == LEN_LO)) len_q[7:0]  <= bus.in_data;
      if (word_done) begin
        addr_q  <= words_q[ADDR_W-1:0];
        words_q <= words_q + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.imem_we     = pk_vld;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_wdata  = pk_word;
  assign core_hold_o     = hold_q;
  assign load_done_o     = done_q;
  assign load_err_o      = err_q;
  assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are parsed by a frame-level
// model and every imem write, its timing and the final status are compared.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rearm = 1'b0;
  logic            core_hold, load_done, load_err;
  logic [ADDR_W:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          wr_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .rearm_i        (rearm),
    .core_hold_o    (core_hold),
    .load_done_o    (load_done),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(bus.imem_addr));
      wr_data.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after acceptance with
  // acc = value cyc holds during the cycle following the accepting edge.
  task automatic send(input logic [7:0] b, input int gaps, output int acc);
    int budget;
    budget = 200;
    acc = -1;
    repeat (gaps) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      acc = cyc + 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  function automatic bq_t mk_frame(input int n, input bit bad);
    bq_t f;
    logic [7:0] x, b;
    f.push_back(8'hA5);
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    x = f[1] ^ f[2];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(bad ? ~x : x);
    return f;
  endfunction

  // Frame-level reference: which words land where, and the final verdict.
  task automatic model(input bq_t fr, output int ea[$], output logic [31:0] ed[$],
                       output int ei[$], output bit dn, output bit er, output int nw);
    int n;
    logic [7:0] x;
    ea.delete(); ed.delete(); ei.delete();
    dn = 0; er = 0; nw = 0;
    n = int'({fr[1], fr[2]});
    if (n > CAP) begin
      er = 1;
      return;
    end
    x = fr[1] ^ fr[2];
    for (int k = 0; k < n; k++) begin
      if (3 + 4 * k + 3 >= fr.size()) break;
      ea.push_back(k);
      ed.push_back({fr[3+4*k], fr[4+4*k], fr[5+4*k], fr[6+4*k]});
      ei.push_back(6 + 4 * k);
      x = x ^ fr[3+4*k] ^ fr[4+4*k] ^ fr[5+4*k] ^ fr[6+4*k];
      nw++;
    end
    if (nw == n && fr.size() > 3 + 4 * n) begin
      if (fr[3+4*n] == x) dn = 1;
      else                er = 1;
    end
  endtask

  task automatic do_rearm(input string tag);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    chk({tag, "_rearm_rdy"},  64'(bus.in_ready), 64'd1);
    chk({tag, "_rearm_hold"}, 64'(core_hold),    64'd1);
    chk({tag, "_rearm_done"}, 64'(load_done),    64'd0);
    chk({tag, "_rearm_err"},  64'(load_err),     64'd0);
  endtask

  task automatic run_frame(input string tag, input bq_t fr, input int junk,
                           input int gapmax, input bit rearm_after);
    int base, a, nw;
    int acc[$];
    int ea[$], ei[$];
    logic [31:0] ed[$];
    logic [7:0] b;
    bit dn, er;
    base = wr_addr.size();
    for (int i = 0; i < junk; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send(b, $urandom_range(gapmax, 0), a);
    end
    foreach (fr[i]) begin
      send(fr[i], $urandom_range(gapmax, 0), a);
      acc.push_back(a);
    end
    repeat (2) @(negedge clk);
    model(fr, ea, ed, ei, dn, er, nw);
    chk({tag, "_nwr"}, 64'(wr_addr.size() - base), 64'(ea.size()));
    foreach (ea[k]) begin
      if (base + k < wr_addr.size()) begin
        chk({tag, "_addr"}, 64'(wr_addr[base+k]), 64'(ea[k]));
        chk({tag, "_data"}, 64'(wr_data[base+k]), 64'(ed[k]));
        chk({tag, "_lat"},  64'(wr_cyc[base+k]),  64'(acc[ei[k]]));
      end
    end
    chk({tag, "_done"},  64'(load_done),       64'(dn));
    chk({tag, "_err"},   64'(load_err),        64'(er));
    chk({tag, "_hold"},  64'(core_hold),       64'(!dn));
    chk({tag, "_rdy"},   64'(bus.in_ready),    64'(!(dn || er)));
    chk({tag, "_words"}, 64'(words_loaded),    64'(nw));
    if (rearm_after) do_rearm(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f2, f3, f;
    int a, base;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold",  64'(core_hold),      64'd1);
    chk("rst_rdy",   64'(bus.in_ready),   64'd0);
    chk("rst_we",    64'(bus.imem_we),    64'd0);
    chk("rst_addr",  64'(bus.imem_addr),  64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_done",  64'(load_done),      64'd0);
    chk("rst_err",   64'(load_err),       64'd0);
    chk("rst_words", 64'(words_loaded),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);

    // Fixed reference frame: two words, checksum 0x47.
    f2 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h47};
    run_frame("t2", f2, 0, 0, 1'b1);

    f3 = f2;
    f3[11] = f3[11] ^ 8'h01;
    run_frame("t3_badchk", f3, 0, 0, 1'b1);

    run_frame("t4_toolong", '{8'hA5, 8'h04, 8'h01}, 0, 0, 1'b1);
    run_frame("t4_zero", '{8'hA5, 8'h00, 8'h00, 8'h00}, 0, 0, 1'b1);
    run_frame("t4_full", mk_frame(CAP, 1'b0), 0, 0, 1'b1);

    run_frame("t5_gaps", f2, 5, 3, 1'b1);

    for (int i = 0; i < 8; i++) begin
      f = mk_frame($urandom_range(6, 1), ($urandom_range(2, 0) == 0));
      run_frame("rnd", f, $urandom_range(3, 0), $urandom_range(3, 0), 1'b1);
    end

    // Reset in the middle of the second word.
    base = wr_addr.size();
    f = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    foreach (f[i]) send(f[i], 0, a);
    repeat (2) @(negedge clk);
    chk("t6_part_nwr", 64'(wr_addr.size() - base), 64'd1);
    if (wr_addr.size() > base) begin
      chk("t6_part_addr", 64'(wr_addr[base]), 64'd0);
      chk("t6_part_data", 64'(wr_data[base]), 64'hDEADBEEF);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_hold",  64'(core_hold),    64'd1);
    chk("t6_rst_rdy",   64'(bus.in_ready), 64'd0);
    chk("t6_rst_words", 64'(words_loaded), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_rdy",  64'(bus.in_ready), 64'd1);
    chk("t6_idle_hold", 64'(core_hold),    64'd1);
    run_frame("t6_new", mk_frame(3, 1'b0), 0, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
